backend_arbiter: RTL and testbench

BACKEND_ARBITER -- requirements
Module: backend_arbiter

---
 rtl/backend_arb_pkg.sv | 18 +
 rtl/backend_arbiter_id_fifo.sv | 71 +++++++
 rtl/backend_arbiter.sv | 137 +++++++++++++
 tb/tb_backend_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backend_arb_pkg.sv
// Shared defaults and the requester-ID type for the backend arbiter.
package backend_arb_pkg;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_TAGS_WIDTH      = 48;
  localparam int DEF_CACHE_SIZE      = 512;
  localparam int DEF_MAX_OUTSTANDING = 4;

  // Requester-ID width: $clog2(n), but never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

  typedef logic [DEF_ID_W-1:0] req_id_t;

endpackage

// File: rtl/backend_arbiter_id_fifo.sv
// Small synchronous FIFO of requester IDs.
// The full and empty flags are registered, so the push side never sees a
// combinational path from the pop side.
module id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // A push while full or a pop while empty is ignored.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // Next pointers, occupancy and the flags derived from it.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control-state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset because the pointers qualify every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: rtl/backend_arbiter.sv
// Round-robin arbiter that merges the address streams of several cache-way
// requesters into one backend reader. It then routes the returned lines back
// to the requesters in the order the addresses were issued.
//
// Handshakes: a transfer happens on a cycle where tvalid and tready are both
// 1 at the rising edge. A source holds tdata and tvalid stable until that
// cycle. tvalid never depends on tready.
module backend_arbiter
  import backend_arb_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int TAGS_WIDTH      = DEF_TAGS_WIDTH,
  parameter int CACHE_SIZE      = DEF_CACHE_SIZE,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata,
  input  logic [NUM_REQ-1:0]            req_addr_tvalid,
  output logic [NUM_REQ-1:0]            req_addr_tready,
  output logic [CACHE_SIZE-1:0]         req_data_tdata,
  output logic [NUM_REQ-1:0]            req_data_tvalid,
  input  logic [NUM_REQ-1:0]            req_data_tready,
  output logic [TAGS_WIDTH-1:0]         mem_addr_tdata,
  output logic                          mem_addr_tvalid,
  input  logic                          mem_addr_tready,
  input  logic [CACHE_SIZE-1:0]         mem_data_tdata,
  input  logic                          mem_data_tvalid,
  output logic                          mem_data_tready,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                          err_unexpected
);

  localparam int IDW = id_width(NUM_REQ);

  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                  out_vld_q, out_vld_d;
  logic [TAGS_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  err_q, err_d;

  logic                  grant_vld;
  logic [IDW-1:0]        grant_idx;
  logic                  can_accept;
  logic                  accept;
  logic                  fifo_full, fifo_empty;
  logic [IDW-1:0]        fifo_head;
  logic                  data_ready;
  logic                  pop;

  // First asserted request at or after rr_ptr, wrapping around.
  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_vld && req_addr_tvalid[IDW'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  // The output register accepts a new address when it is empty or draining.
  // A pop in the same cycle cannot free the FIFO for a push.
  assign can_accept = ~rst & (~out_vld_q | mem_addr_tready) & ~fifo_full;
  assign accept     = grant_vld & can_accept;

  // Ready goes only to the granted requester.
  always_comb begin
    req_addr_tready = '0;
    if (accept) req_addr_tready[grant_idx] = 1'b1;
  end

  // Next state of the output register, the pointer and the error flag.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_addr_d = out_addr_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q | (mem_data_tvalid & fifo_empty);
    if (out_vld_q && mem_addr_tready) out_vld_d = 1'b0;
    if (accept) begin
      out_vld_d  = 1'b1;
      out_addr_d = req_addr_tdata[int'(grant_idx)*TAGS_WIDTH +: TAGS_WIDTH];
      rr_ptr_d   = IDW'((int'(grant_idx) + 1) % NUM_REQ);
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      err_q      <= err_d;
    end
  end

  id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (grant_idx),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // Steer the returned line to the requester at the FIFO head. With the
  // FIFO empty, the beat is held off and nothing is delivered.
  assign data_ready      = ~rst & ~fifo_empty & req_data_tready[fifo_head];
  assign mem_data_tready = data_ready;
  assign pop             = mem_data_tvalid & data_ready;

  // The valid bit is raised only for the head requester.
  always_comb begin
    req_data_tvalid = '0;
    if (!rst && !fifo_empty) req_data_tvalid[fifo_head] = mem_data_tvalid;
  end

  assign req_data_tdata  = mem_data_tdata;
  assign mem_addr_tdata  = out_addr_q;
  assign mem_addr_tvalid = out_vld_q & ~rst;
  assign err_unexpected  = err_q;

endmodule

// File: tb/tb_backend_arbiter.sv
// Directed bench for backend_arbiter with default parameters.
module tb_backend_arbiter;

  localparam int NR = 4;
  localparam int TW = 48;
  localparam int CS = 512;

  logic             clk;
  logic             rst;
  logic [NR*TW-1:0] req_addr_tdata;
  logic [NR-1:0]    req_addr_tvalid;
  logic [NR-1:0]    req_addr_tready;
  logic [CS-1:0]    req_data_tdata;
  logic [NR-1:0]    req_data_tvalid;
  logic [NR-1:0]    req_data_tready;
  logic [TW-1:0]    mem_addr_tdata;
  logic             mem_addr_tvalid;
  logic             mem_addr_tready;
  logic [CS-1:0]    mem_data_tdata;
  logic             mem_data_tvalid;
  logic             mem_data_tready;
  logic [2:0]       outstanding;
  logic             err_unexpected;

  int total = 0;
  int bad   = 0;

  logic [TW-1:0] exp_q[$];
  logic [NR-1:0] exp_id_q[$];

  backend_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req_addr_tdata  (req_addr_tdata),
    .req_addr_tvalid (req_addr_tvalid),
    .req_addr_tready (req_addr_tready),
    .req_data_tdata  (req_data_tdata),
    .req_data_tvalid (req_data_tvalid),
    .req_data_tready (req_data_tready),
    .mem_addr_tdata  (mem_addr_tdata),
    .mem_addr_tvalid (mem_addr_tvalid),
    .mem_addr_tready (mem_addr_tready),
    .mem_data_tdata  (mem_data_tdata),
    .mem_data_tvalid (mem_data_tvalid),
    .mem_data_tready (mem_data_tready),
    .outstanding     (outstanding),
    .err_unexpected  (err_unexpected)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [TW-1:0] a);
    req_addr_tdata[i*TW +: TW] = a;
  endtask

  task automatic idle_inputs();
    req_addr_tdata  = '0;
    req_addr_tvalid = '0;
    req_data_tready = '1;
    mem_addr_tready = 1'b1;
    mem_data_tdata  = '0;
    mem_data_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    req_addr_tvalid = '1;
    req_data_tready = '1;
    mem_addr_tready = 1'b1;
    mem_data_tvalid = 1'b1;
    cycle();
    total++; if (req_addr_tready !== 4'b0000) begin bad++; $display("FAIL rst_addr_tready: got %b exp 0000", req_addr_tready); end
    total++; if (mem_addr_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mem_addr_tvalid: got %b exp 0", mem_addr_tvalid); end
    total++; if (mem_data_tready !== 1'b0) begin bad++; $display("FAIL rst_mem_data_tready: got %b exp 0", mem_data_tready); end
    total++; if (req_data_tvalid !== 4'b0000) begin bad++; $display("FAIL rst_req_data_tvalid: got %b exp 0000", req_data_tvalid); end
    cycle();
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rst_outstanding: got %0d exp 0", outstanding); end
    total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL rst_err: got %b exp 0", err_unexpected); end
    total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL rst_rr_ptr: got %0d exp 0", dut.rr_ptr_q); end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [CS-1:0] line;
    line = {16{32'hA5A5_0001}};
    do_reset();
    set_addr(1, 48'h5);
    req_addr_tvalid = 4'b0010;
    #1;
    total++; if (req_addr_tready !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b exp 0010", req_addr_tready); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL single_occ0: got %0d exp 0", outstanding); end
    cycle();
    req_addr_tvalid = '0;
    #1;
    total++; if (mem_addr_tvalid !== 1'b1) begin bad++; $display("FAIL single_mem_vld: got %b exp 1", mem_addr_tvalid); end
    total++; if (mem_addr_tdata !== 48'h5) begin bad++; $display("FAIL single_mem_addr: got %h exp 5", mem_addr_tdata); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL single_occ1: got %0d exp 1", outstanding); end
    cycle();
    total++; if (mem_addr_tvalid !== 1'b0) begin bad++; $display("FAIL single_mem_drain: got %b exp 0", mem_addr_tvalid); end
    mem_data_tdata  = line;
    mem_data_tvalid = 1'b1;
    #1;
    total++; if (req_data_tvalid !== 4'b0010) begin bad++; $display("FAIL single_route: got %b exp 0010", req_data_tvalid); end
    total++; if (req_data_tdata !== line) begin bad++; $display("FAIL single_line: got %h exp %h", req_data_tdata, line); end
    total++; if (mem_data_tready !== 1'b1) begin bad++; $display("FAIL single_data_rdy: got %b exp 1", mem_data_tready); end
    cycle();
    mem_data_tvalid = 1'b0;
    #1;
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL single_occ_back: got %0d exp 0", outstanding); end
    total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL single_err: got %b exp 0", err_unexpected); end
  endtask

  task automatic test_round_robin();
    int            grants [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] exp_rdy;
    logic [TW-1:0] exp_a;
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, 48'h100 + 48'(i));
    req_addr_tvalid = '1;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      mem_data_tvalid = (k > 0);
      #1;
      exp_rdy = 4'(1 << grants[k]);
      total++; if (req_addr_tready !== exp_rdy) begin bad++; $display("FAIL rr_grant%0d: got %b exp %b", k, req_addr_tready, exp_rdy); end
      if (k > 0) begin
        exp_a = exp_q.pop_front();
        total++; if (mem_addr_tdata !== exp_a) begin bad++; $display("FAIL rr_addr%0d: got %h exp %h", k, mem_addr_tdata, exp_a); end
        exp_rdy = 4'(1 << grants[k-1]);
        total++; if (req_data_tvalid !== exp_rdy) begin bad++; $display("FAIL rr_route%0d: got %b exp %b", k, req_data_tvalid, exp_rdy); end
      end
      exp_q.push_back(48'h100 + 48'(grants[k]));
      cycle();
    end
    req_addr_tvalid = '0;
    #1;
    exp_a = exp_q.pop_front();
    total++; if (mem_addr_tdata !== exp_a || mem_addr_tvalid !== 1'b1) begin bad++; $display("FAIL rr_last_addr: got %h exp %h", mem_addr_tdata, exp_a); end
    cycle();
    mem_data_tvalid = 1'b0;
  endtask

  task automatic test_addr_backpressure();
    do_reset();
    set_addr(0, 48'h111);
    set_addr(2, 48'h222);
    req_addr_tvalid = 4'b0101;
    mem_addr_tready = 1'b0;
    #1;
    total++; if (req_addr_tready !== 4'b0001) begin bad++; $display("FAIL bp_first: got %b exp 0001", req_addr_tready); end
    cycle();
    for (int k = 0; k < 5; k++) begin
      total++; if (req_addr_tready !== 4'b0000) begin bad++; $display("FAIL bp_rdy%0d: got %b exp 0000", k, req_addr_tready); end
      total++; if (mem_addr_tvalid !== 1'b1 || mem_addr_tdata !== 48'h111) begin bad++; $display("FAIL bp_hold%0d: got %b/%h exp 1/111", k, mem_addr_tvalid, mem_addr_tdata); end
      total++; if (dut.rr_ptr_q !== 2'd1) begin bad++; $display("FAIL bp_ptr%0d: got %0d exp 1", k, dut.rr_ptr_q); end
      cycle();
    end
    mem_addr_tready = 1'b1;
    #1;
    total++; if (req_addr_tready !== 4'b0100) begin bad++; $display("FAIL bp_resume: got %b exp 0100", req_addr_tready); end
    cycle();
    req_addr_tvalid = '0;
    #1;
    total++; if (mem_addr_tdata !== 48'h222) begin bad++; $display("FAIL bp_next_addr: got %h exp 222", mem_addr_tdata); end
    total++; if (dut.rr_ptr_q !== 2'd3) begin bad++; $display("FAIL bp_ptr_after: got %0d exp 3", dut.rr_ptr_q); end
  endtask

  task automatic test_fifo_full();
    logic [NR-1:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, 48'h300 + 48'(i));
    req_addr_tvalid = '1;
    for (int i = 0; i < NR; i++) begin
      #1;
      exp_rdy = 4'(1 << i);
      total++; if (req_addr_tready !== exp_rdy) begin bad++; $display("FAIL full_grant%0d: got %b exp %b", i, req_addr_tready, exp_rdy); end
      cycle();
    end
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_occ: got %0d exp 4", outstanding); end
    total++; if (req_addr_tready !== 4'b0000) begin bad++; $display("FAIL full_block: got %b exp 0000", req_addr_tready); end
    mem_data_tdata  = {16{32'hC0DE_0000}};
    mem_data_tvalid = 1'b1;
    #1;
    total++; if (req_data_tvalid !== 4'b0001) begin bad++; $display("FAIL full_route: got %b exp 0001", req_data_tvalid); end
    total++; if (req_addr_tready !== 4'b0000) begin bad++; $display("FAIL full_pop_block: got %b exp 0000", req_addr_tready); end
    cycle();
    mem_data_tvalid = 1'b0;
    #1;
    total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL full_occ3: got %0d exp 3", outstanding); end
    total++; if (req_addr_tready !== 4'b0001) begin bad++; $display("FAIL full_resume: got %b exp 0001", req_addr_tready); end
    cycle();
    req_addr_tvalid = '0;
    #1;
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_refill: got %0d exp 4", outstanding); end
  endtask

  task automatic test_head_of_line();
    logic [CS-1:0] line_a;
    logic [CS-1:0] line_b;
    logic [NR-1:0] exp_v;
    line_a = {16{32'hAAAA_0002}};
    line_b = {16{32'hBBBB_0000}};
    do_reset();
    exp_id_q.delete();
    set_addr(2, 48'h222);
    set_addr(0, 48'h000);
    req_data_tready = 4'b1011;
    req_addr_tvalid = 4'b0100;
    #1;
    total++; if (req_addr_tready !== 4'b0100) begin bad++; $display("FAIL hol_grant2: got %b exp 0100", req_addr_tready); end
    exp_id_q.push_back(4'b0100);
    cycle();
    req_addr_tvalid = 4'b0001;
    #1;
    total++; if (req_addr_tready !== 4'b0001) begin bad++; $display("FAIL hol_grant0: got %b exp 0001", req_addr_tready); end
    exp_id_q.push_back(4'b0001);
    cycle();
    req_addr_tvalid = '0;
    mem_data_tdata  = line_a;
    mem_data_tvalid = 1'b1;
    #1;
    exp_v = exp_id_q[0];
    for (int k = 0; k < 3; k++) begin
      total++; if (req_data_tvalid !== exp_v) begin bad++; $display("FAIL hol_route%0d: got %b exp %b", k, req_data_tvalid, exp_v); end
      total++; if (mem_data_tready !== 1'b0) begin bad++; $display("FAIL hol_stall%0d: got %b exp 0", k, mem_data_tready); end
      total++; if (outstanding !== 3'd2) begin bad++; $display("FAIL hol_occ%0d: got %0d exp 2", k, outstanding); end
      cycle();
    end
    req_data_tready = '1;
    #1;
    total++; if (mem_data_tready !== 1'b1) begin bad++; $display("FAIL hol_release: got %b exp 1", mem_data_tready); end
    void'(exp_id_q.pop_front());
    cycle();
    mem_data_tdata = line_b;
    #1;
    exp_v = exp_id_q.pop_front();
    total++; if (req_data_tvalid !== exp_v) begin bad++; $display("FAIL hol_order: got %b exp %b", req_data_tvalid, exp_v); end
    total++; if (req_data_tdata !== line_b) begin bad++; $display("FAIL hol_line_b: got %h exp %h", req_data_tdata, line_b); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL hol_occ1: got %0d exp 1", outstanding); end
    cycle();
    mem_data_tvalid = 1'b0;
    #1;
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL hol_occ0: got %0d exp 0", outstanding); end
  endtask

  task automatic test_err_and_reset();
    logic [NR-1:0] exp_rdy;
    do_reset();
    mem_data_tvalid = 1'b1;
    #1;
    total++; if (mem_data_tready !== 1'b0) begin bad++; $display("FAIL err_stall: got %b exp 0", mem_data_tready); end
    total++; if (req_data_tvalid !== 4'b0000) begin bad++; $display("FAIL err_no_route: got %b exp 0000", req_data_tvalid); end
    total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL err_pre: got %b exp 0", err_unexpected); end
    cycle();
    mem_data_tvalid = 1'b0;
    #1;
    total++; if (err_unexpected !== 1'b1) begin bad++; $display("FAIL err_set: got %b exp 1", err_unexpected); end
    repeat (3) cycle();
    total++; if (err_unexpected !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b exp 1", err_unexpected); end
    for (int i = 0; i < 3; i++) set_addr(i, 48'h400 + 48'(i));
    req_addr_tvalid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_rdy = 4'(1 << i);
      total++; if (req_addr_tready !== exp_rdy) begin bad++; $display("FAIL err_grant%0d: got %b exp %b", i, req_addr_tready, exp_rdy); end
      cycle();
    end
    req_addr_tvalid = '0;
    #1;
    total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL err_occ3: got %0d exp 3", outstanding); end
    total++; if (mem_addr_tvalid !== 1'b1) begin bad++; $display("FAIL err_addr_vld: got %b exp 1", mem_addr_tvalid); end
    rst = 1'b1;
    #1;
    total++; if (mem_addr_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_vld: got %b exp 0", mem_addr_tvalid); end
    cycle();
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL mid_rst_occ: got %0d exp 0", outstanding); end
    rst = 1'b0;
    #1;
    total++; if (mem_addr_tvalid !== 1'b0) begin bad++; $display("FAIL post_rst_vld: got %b exp 0", mem_addr_tvalid); end
    total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL post_rst_err: got %b exp 0", err_unexpected); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_addr_backpressure();
    test_fifo_full();
    test_head_of_line();
    test_err_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
